// File: rtl/cifrador_pkg.sv
// Shared types and constants for the cifrador keystream generator:
// FSM state encoding, LFSR feedback mask, default seed and the single-step function.
package cifrador_pkg;

    typedef enum logic [1:0] {
        LOAD_LO = 2'd0,
        LOAD_HI = 2'd1,
        WARM    = 2'd2,
        RUN     = 2'd3
    } ks_state_t;

    localparam logic [15:0] LFSR_MASK          = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT_VALUE = 16'hACE1;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] shifted;
        shifted = s >> 1;
        return s[0] ? (shifted ^ LFSR_MASK) : shifted;
    endfunction

endpackage

// File: rtl/cifrador_lfsr_step8.sv
// Combinational eight-step LFSR advance, used to produce one keystream byte per cycle.
module cifrador_lfsr_step8
    import cifrador_pkg::*;
(
    input  logic [15:0] state,
    output logic [15:0] state8
);

    logic [15:0] chain;

    always_comb begin
        chain = state;
        for (int i = 0; i < 8; i++) begin
            chain = lfsr_step(chain);
        end
        state8 = chain;
    end

endmodule

// File: rtl/cifrador_keystream.sv
// Keystream generator: loads a 16-bit key as two bytes, warms up a Galois LFSR, then
// streams one byte per cycle. Define CIFRADOR_KS_WHITEN_EN to mix the high byte into the output.
module cifrador_keystream
    import cifrador_pkg::*;
#(
    parameter int          WARMUP       = 16,
    parameter logic [15:0] SEED_DEFAULT = SEED_DEFAULT_VALUE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] key_byte,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       rekey,
    output logic [7:0] ks_byte,
    output logic       ks_valid,
    input  logic       ks_ready,
    output logic       busy
);

    localparam logic [8:0] WARMUP_W = 9'(WARMUP);

    ks_state_t   state_reg, state_next;
    logic [15:0] lfsr_reg, lfsr_next;
    logic [7:0]  seed_reg, seed_next;
    logic [7:0]  cnt_reg, cnt_next;

    logic        key_fire;
    logic        ks_fire;
    logic        warm_done;
    logic [15:0] key_word;
    logic [15:0] lfsr_adv8;

    cifrador_lfsr_step8 u_step8 (
        .state  (lfsr_reg),
        .state8 (lfsr_adv8)
    );

    assign key_ready = ena && ((state_reg == LOAD_LO) || (state_reg == LOAD_HI));
    assign ks_valid  = ena && (state_reg == RUN);
    assign busy      = (state_reg == WARM);

    assign key_fire  = key_valid && key_ready;
    assign ks_fire   = ks_valid && ks_ready;
    assign warm_done = (({1'b0, cnt_reg} + 9'd1) == WARMUP_W);
    assign key_word  = {key_byte, seed_reg};

`ifdef CIFRADOR_KS_WHITEN_EN
    assign ks_byte = lfsr_reg[7:0] ^ {lfsr_reg[12:8], lfsr_reg[15:13]};
`else
    assign ks_byte = lfsr_reg[7:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOAD_LO;
            lfsr_reg  <= SEED_DEFAULT;
            seed_reg  <= 8'd0;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            seed_reg  <= seed_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Outside RUN, rekey wins over any key transfer or warm-up step in the same cycle.
    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        seed_next  = seed_reg;
        cnt_next   = cnt_reg;
        if (ena) begin
            case (state_reg)
                LOAD_LO: begin
                    if (rekey) begin
                        state_next = LOAD_LO;
                    end else if (key_fire) begin
                        seed_next  = key_byte;
                        state_next = LOAD_HI;
                    end
                end
                LOAD_HI: begin
                    if (rekey) begin
                        state_next = LOAD_LO;
                    end else if (key_fire) begin
                        lfsr_next  = (key_word == 16'd0) ? SEED_DEFAULT : key_word;
                        cnt_next   = 8'd0;
                        state_next = (WARMUP == 0) ? RUN : WARM;
                    end
                end
                WARM: begin
                    if (rekey) begin
                        state_next = LOAD_LO;
                    end else begin
                        lfsr_next = lfsr_step(lfsr_reg);
                        cnt_next  = cnt_reg + 8'd1;
                        if (warm_done) begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (ks_fire) begin
                        lfsr_next = lfsr_adv8;
                    end
                    if (rekey) begin
                        state_next = LOAD_LO;
                    end
                end
                default: state_next = LOAD_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_cifrador_keystream.sv
// Directed bench for cifrador_keystream: one instance with WARMUP=0 (a), one with WARMUP=16 (b).
module tb_cifrador_keystream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ena_a, key_valid_a, rekey_a, ks_ready_a;
    logic [7:0] key_byte_a;
    logic       key_ready_a, ks_valid_a, busy_a;
    logic [7:0] ks_byte_a;
    logic       ena_b, key_valid_b, rekey_b, ks_ready_b;
    logic [7:0] key_byte_b;
    logic       key_ready_b, ks_valid_b, busy_b;
    logic [7:0] ks_byte_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Hand-computed bytes for the seed 0xACE1 sequence:
    // lfsr ACE1 -> C2C4 -> EB62 -> 753B -> 330D (8 steps each); 0E27 after 5 single steps.
`ifdef CIFRADOR_KS_WHITEN_EN
    localparam logic [7:0] EXP_B0 = 8'h84, EXP_B1 = 8'hD2, EXP_B2 = 8'h3D, EXP_B3 = 8'h90;
    localparam logic [7:0] EXP_REKEY = 8'h94, EXP_W5 = 8'h57;
`else
    localparam logic [7:0] EXP_B0 = 8'hE1, EXP_B1 = 8'hC4, EXP_B2 = 8'h62, EXP_B3 = 8'h3B;
    localparam logic [7:0] EXP_REKEY = 8'h0D, EXP_W5 = 8'h27;
`endif

    cifrador_keystream #(.WARMUP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .key_byte(key_byte_a), .key_valid(key_valid_a),
        .key_ready(key_ready_a), .rekey(rekey_a), .ks_byte(ks_byte_a), .ks_valid(ks_valid_a),
        .ks_ready(ks_ready_a), .busy(busy_a)
    );

    cifrador_keystream #(.WARMUP(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b), .key_byte(key_byte_b), .key_valid(key_valid_b),
        .key_ready(key_ready_b), .rekey(rekey_b), .ks_byte(ks_byte_b), .ks_valid(ks_valid_b),
        .ks_ready(ks_ready_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena_a = 1'b1; key_valid_a = 1'b0; rekey_a = 1'b0; ks_ready_a = 1'b0; key_byte_a = 8'h00;
        ena_b = 1'b1; key_valid_b = 1'b0; rekey_b = 1'b0; ks_ready_b = 1'b0; key_byte_b = 8'h00;
        repeat (2) tick();
        total_cnt++; if (key_ready_a !== 1'b1) $display("FAIL reset_key_ready got %b want 1", key_ready_a); else pass_cnt++;
        total_cnt++; if (ks_valid_a !== 1'b0) $display("FAIL reset_ks_valid got %b want 0", ks_valid_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (ks_byte_a !== EXP_B0) $display("FAIL reset_ks_byte got %h want %h", ks_byte_a, EXP_B0); else pass_cnt++;
        total_cnt++; if (ks_byte_b !== EXP_B0) $display("FAIL reset_ks_byte_b got %h want %h", ks_byte_b, EXP_B0); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        $display("reset: key_ready=%b ks_valid=%b busy=%b ks_byte=%h", key_ready_a, ks_valid_a, busy_a, ks_byte_a);
    endtask

    task automatic test_stream_w0();
        ks_ready_a = 1'b1;
        key_valid_a = 1'b1; key_byte_a = 8'hE1; tick();
        key_byte_a = 8'hAC; tick();
        key_valid_a = 1'b0;
        total_cnt++; if (ks_valid_a !== 1'b1) $display("FAIL w0_first_valid got %b want 1", ks_valid_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL w0_busy got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (key_ready_a !== 1'b0) $display("FAIL w0_key_ready got %b want 0", key_ready_a); else pass_cnt++;
        total_cnt++; if (ks_byte_a !== EXP_B0) $display("FAIL w0_byte0 got %h want %h", ks_byte_a, EXP_B0); else pass_cnt++;
        $display("stream w0: byte0=%h", ks_byte_a);
        tick();
        total_cnt++; if (ks_byte_a !== EXP_B1 || ks_valid_a !== 1'b1) $display("FAIL w0_byte1 got %h/%b want %h/1", ks_byte_a, ks_valid_a, EXP_B1); else pass_cnt++;
        $display("stream w0: byte1=%h", ks_byte_a);
        tick();
        total_cnt++; if (ks_byte_a !== EXP_B2 || ks_valid_a !== 1'b1) $display("FAIL w0_byte2 got %h/%b want %h/1", ks_byte_a, ks_valid_a, EXP_B2); else pass_cnt++;
        $display("stream w0: byte2=%h", ks_byte_a);
        tick();
        total_cnt++; if (ks_byte_a !== EXP_B3 || ks_valid_a !== 1'b1) $display("FAIL w0_byte3 got %h/%b want %h/1", ks_byte_a, ks_valid_a, EXP_B3); else pass_cnt++;
        $display("stream w0: byte3=%h", ks_byte_a);
    endtask

    task automatic test_rekey_run();
        rekey_a = 1'b1;
        tick();
        rekey_a = 1'b0;
        total_cnt++; if (ks_valid_a !== 1'b0) $display("FAIL rekey_ks_valid got %b want 0", ks_valid_a); else pass_cnt++;
        total_cnt++; if (key_ready_a !== 1'b1) $display("FAIL rekey_key_ready got %b want 1", key_ready_a); else pass_cnt++;
        total_cnt++; if (ks_byte_a !== EXP_REKEY) $display("FAIL rekey_consumed got %h want %h", ks_byte_a, EXP_REKEY); else pass_cnt++;
        $display("rekey: ks_valid=%b key_ready=%b ks_byte=%h", ks_valid_a, key_ready_a, ks_byte_a);
    endtask

    task automatic test_zero_key();
        key_valid_a = 1'b1; key_byte_a = 8'h00; tick();
        tick();
        key_valid_a = 1'b0;
        total_cnt++; if (ks_byte_a !== EXP_B0 || ks_valid_a !== 1'b1) $display("FAIL zero_key_byte0 got %h/%b want %h/1", ks_byte_a, ks_valid_a, EXP_B0); else pass_cnt++;
        tick();
        total_cnt++; if (ks_byte_a !== EXP_B1) $display("FAIL zero_key_byte1 got %h want %h", ks_byte_a, EXP_B1); else pass_cnt++;
        $display("zero key: byte1=%h", ks_byte_a);
    endtask

    task automatic test_stall();
        ks_ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (ks_byte_a !== EXP_B1 || ks_valid_a !== 1'b1) $display("FAIL stall_hold%0d got %h/%b want %h/1", i, ks_byte_a, ks_valid_a, EXP_B1); else pass_cnt++;
            $display("stall %0d: ks_byte=%h ks_valid=%b", i, ks_byte_a, ks_valid_a);
        end
        ks_ready_a = 1'b1;
        tick();
        total_cnt++; if (ks_byte_a !== EXP_B2) $display("FAIL stall_release1 got %h want %h", ks_byte_a, EXP_B2); else pass_cnt++;
        tick();
        total_cnt++; if (ks_byte_a !== EXP_B3) $display("FAIL stall_release2 got %h want %h", ks_byte_a, EXP_B3); else pass_cnt++;
        $display("stall release: byte=%h", ks_byte_a);
    endtask

    task automatic test_reset_mid_run();
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (ks_valid_a !== 1'b0) $display("FAIL midreset_ks_valid got %b want 0", ks_valid_a); else pass_cnt++;
        total_cnt++; if (key_ready_a !== 1'b1) $display("FAIL midreset_key_ready got %b want 1", key_ready_a); else pass_cnt++;
        total_cnt++; if (ks_byte_a !== EXP_B0) $display("FAIL midreset_ks_byte got %h want %h", ks_byte_a, EXP_B0); else pass_cnt++;
        #2;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (key_ready_a !== 1'b1 || ks_valid_a !== 1'b0) $display("FAIL midreset_after got %b/%b want 1/0", key_ready_a, ks_valid_a); else pass_cnt++;
        $display("mid-run reset: key_ready=%b ks_byte=%h", key_ready_a, ks_byte_a);
    endtask

    task automatic test_warmup();
        key_valid_b = 1'b1; key_byte_b = 8'hE1; tick();
        key_byte_b = 8'hAC; tick();
        key_valid_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                total_cnt++; if (ks_byte_b !== EXP_W5) $display("FAIL warm_step5 got %h want %h", ks_byte_b, EXP_W5); else pass_cnt++;
                ena_b = 1'b0; rekey_b = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    tick();
                    total_cnt++; if (busy_b !== 1'b1 || ks_valid_b !== 1'b0 || key_ready_b !== 1'b0) $display("FAIL freeze%0d_flags got busy=%b valid=%b ready=%b want 1/0/0", j, busy_b, ks_valid_b, key_ready_b); else pass_cnt++;
                    total_cnt++; if (ks_byte_b !== EXP_W5) $display("FAIL freeze%0d_byte got %h want %h", j, ks_byte_b, EXP_W5); else pass_cnt++;
                    $display("freeze %0d: busy=%b ks_byte=%h", j, busy_b, ks_byte_b);
                end
                ena_b = 1'b1; rekey_b = 1'b0;
            end
            total_cnt++; if (busy_b !== 1'b1 || ks_valid_b !== 1'b0) $display("FAIL warm%0d got busy=%b valid=%b want 1/0", i, busy_b, ks_valid_b); else pass_cnt++;
            tick();
        end
        total_cnt++; if (busy_b !== 1'b0 || ks_valid_b !== 1'b1) $display("FAIL warm_end got busy=%b valid=%b want 0/1", busy_b, ks_valid_b); else pass_cnt++;
        total_cnt++; if (ks_byte_b !== EXP_B2) $display("FAIL warm_first_byte got %h want %h", ks_byte_b, EXP_B2); else pass_cnt++;
        $display("warmup 16: busy=%b ks_valid=%b ks_byte=%h", busy_b, ks_valid_b, ks_byte_b);
    endtask

    initial begin
        test_reset();
        test_stream_w0();
        test_rekey_run();
        test_zero_key();
        test_stall();
        test_reset_mid_run();
        test_warmup();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/cifrador_keystream.md
# cifrador_keystream

Keystream generator that feeds the 8-bit cipher core of `tt_um_cifrador_8bits`. It loads a 16-bit key as two bytes over a valid/ready handshake and seeds a Galois LFSR with it. After a warm-up run it streams one keystream byte per cycle over a second valid/ready handshake. The cipher core XORs these bytes with plaintext.

## Interface
- `WARMUP`, 16: LFSR single-steps run after seeding and before the first output byte; range 0..255.
- `SEED_DEFAULT`, 16'hACE1: substitute seed when the loaded key is 0, and the reset value of `lfsr`.
- Reset is asynchronous and active-low; one clock.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  design enable. Low freezes all state.
- `key_byte`  in  8  key byte. Low byte first, then high byte.
- `key_valid`  in  1  `key_byte` is valid.
- `key_ready`  out  1  block accepts a key byte.
- `rekey`  in  1  single-cycle request to discard the current key and reload.
- `ks_byte`  out  8  keystream byte.
- `ks_valid`  out  1  `ks_byte` is valid.
- `ks_ready`  in  1  cipher core consumes `ks_byte`.
- `busy`  out  1  high during warm-up.

## Operation
- States: LOAD_LO, LOAD_HI, WARM, RUN. Reset state is LOAD_LO.
- `key_ready` = `ena` and (state is LOAD_LO or LOAD_HI).
- `ks_valid` = `ena` and state is RUN.
- `busy` = state is WARM.
- A key transfer happens when `key_valid` and `key_ready` are both high.
  - In LOAD_LO: `seed[7:0]` is captured; go to LOAD_HI.
  - In LOAD_HI: `lfsr` is loaded with `{key_byte, seed[7:0]}`, or with `SEED_DEFAULT` if that value is 0. The warm-up counter is cleared; go to WARM.
  - If `WARMUP` = 0, go straight to RUN instead of WARM.
- LFSR step:
  - Galois, right-shifting, mask 16'hB400 (polynomial x^16+x^14+x^13+x^11+1).
  - Computed as: `lsb = s[0]; s = s >> 1; if lsb then s ^= 16'hB400`.
- WARM: one step per enabled cycle. After `WARMUP` steps, go to RUN.
- RUN:
  - `ks_byte` = f(`lfsr`), where f depends only on the `lfsr` register, with no input-to-output path.
  - On a keystream transfer (`ks_valid` and `ks_ready` high), `lfsr` advances exactly 8 steps in that cycle.
  - Sustained throughput is 1 byte per cycle.
- `rekey` in RUN:
  - A keystream transfer in the same cycle still completes and `lfsr` advances.
  - The state then goes to LOAD_LO.
- `rekey` in any other state resets the state to LOAD_LO; `seed` and `lfsr` are kept.
- `ena` low:
  - State, counter, `seed` and `lfsr` hold.
  - `key_ready` and `ks_valid` are forced to 0.
  - Inputs are ignored, including `rekey`.
- Reset values:
  - State LOAD_LO, `lfsr` = `SEED_DEFAULT`, `seed` = 0, counter = 0.
  - `ks_valid` = 0, `busy` = 0, `key_ready` = `ena`.
  - `ks_byte` = f(`SEED_DEFAULT`).

## Timing
- Key high-byte transfer at cycle t:
  - With `WARMUP` = N > 0: `busy` is high in cycles t+1..t+N; `ks_valid` first rises at t+N+1.
  - With N = 0: `ks_valid` rises at t+1.
- The next `ks_byte` is valid in the cycle after a transfer.
- `ks_valid` stays high back-to-back while in RUN.
- `rekey` at cycle t: `ks_valid` = 0 and `key_ready` = 1 at t+1.
- Reset asserted mid-stream: outputs take their reset values immediately. They are not re-timed to the clock.

## Configuration
- `CIFRADOR_KS_WHITEN_EN` defined: f(s) = `s[7:0] ^ {s[12:8], s[15:13]}`, i.e. the high byte rotated left by 3, XOR the low byte.
- Not defined: f(s) = `s[7:0]`.
- Handshakes, latency and LFSR sequence are identical in both builds.

## Structure
- `cifrador_pkg` holds:
  - the state enum;
  - `LFSR_MASK` = 16'hB400;
  - the default seed constant;
  - the single-step function.
- Sub-module `cifrador_lfsr_step8`: combinational 8-step advance, built from 8 chained single steps. It is instantiated once for the RUN path.
- The WARM path uses the single-step function.

## Test plan
- Reset with `ena` = 1:
  - `key_ready` = 1, `ks_valid` = 0, `busy` = 0.
  - `ks_byte` = 0xE1 (0x84 with whiten).
- `WARMUP` = 0, key bytes 0xE1 then 0xAC, `ks_ready` = 1:
  - stream starts 0xE1 then 0xC4, since `lfsr` after 8 steps is 0xC2C4.
  - With whiten, the first byte is 0x84.
- Key bytes 0x00, 0x00 with `WARMUP` = 0 → the seed is replaced by 0xACE1, giving the same stream as the previous scenario.
- `WARMUP` = 16:
  - `busy` is high for exactly 16 cycles after the high-byte transfer.
  - `ks_valid` rises on the 17th cycle.
- `ks_ready` held low for 5 cycles in RUN → `ks_byte` and `lfsr` are stable during the stall; no byte is skipped after release.
- Combined events:
  - `rekey` in the same cycle as a keystream transfer → the byte counts as consumed and `ks_valid` = 0 next cycle.
  - `ena` = 0 mid-WARM → `busy` holds and the counter freezes.
  - Reset pulse mid-RUN → back to LOAD_LO with `lfsr` = 0xACE1.
